// File: rtl/llr_block_to_stream.sv
// rtl/llr_block_to_stream.sv - frame-parallel LLR block replayed as a one-symbol-per-cycle stream
module llr_block_to_stream #(
  parameter int BITS            = 32,
  parameter int BITS_PER_SYMBOL = 2,
  parameter int SYMBOLS         = 29,
  parameter int GAP             = 0
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [BITS_PER_SYMBOL*SYMBOLS*BITS-1:0] encoder1_data_in,
  input  logic [BITS_PER_SYMBOL*SYMBOLS*BITS-1:0] encoder2_data_in,
  input  logic [BITS_PER_SYMBOL*SYMBOLS*BITS-1:0] extrinsic_in,
  output logic                                    out_valid,
  output logic [BITS_PER_SYMBOL*BITS-1:0]         encoder1_data_out,
  output logic [BITS_PER_SYMBOL*BITS-1:0]         encoder2_data_out,
  output logic [BITS_PER_SYMBOL*BITS-1:0]         extrinsic_out,
  output logic                                    frame_first,
  output logic                                    frame_last,
  output logic                                    overflow
);

  localparam int AW = BITS_PER_SYMBOL * SYMBOLS * BITS;  // one LLR array
  localparam int FW = 3 * AW;                            // whole frame {ext, enc2, enc1}
  localparam int OW = BITS_PER_SYMBOL * BITS;            // one symbol of one array
  localparam int SW = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
  localparam logic [SW-1:0] LAST = SW'(SYMBOLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sym_q, sym_d;
  logic [7:0]      gap_q, gap_d;
  logic [FW-1:0]   act_q, act_d;
  logic [FW-1:0]   pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic            valid_q, valid_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic            ovf_q, ovf_d;
  logic [3*OW-1:0] dout_q, dout_d;

  logic            capture;
  logic            load;
  logic [FW-1:0]   in_frame;
  logic [FW-1:0]   load_src;
  logic [SW-1:0]   sym_nxt;

  // Gather symbol s of every array of a frame into {ext, enc2, enc1} output order.
  function automatic logic [3*OW-1:0] pick(input logic [FW-1:0] f, input logic [SW-1:0] s);
    logic [3*OW-1:0] r;
    r = '0;
    for (int a = 0; a < 3; a++) begin
      for (int j = 0; j < BITS_PER_SYMBOL; j++) begin
        r[a*OW + j*BITS +: BITS] = f[a*AW + (j*SYMBOLS + int'(s))*BITS +: BITS];
      end
    end
    return r;
  endfunction

  assign in_frame = {extrinsic_in, encoder2_data_in, encoder1_data_in};
  assign capture  = in_valid && !pend_full_q;
  assign in_ready = !pend_full_q;

  assign out_valid         = valid_q;
  assign frame_first       = first_q;
  assign frame_last        = last_q;
  assign overflow          = ovf_q;
  assign encoder1_data_out = dout_q[0    +: OW];
  assign encoder2_data_out = dout_q[OW   +: OW];
  assign extrinsic_out     = dout_q[2*OW +: OW];

  // Next-state: pending capture, frame sequencing and the registered symbol outputs.
  always_comb begin
    state_d     = state_q;
    sym_d       = sym_q;
    gap_d       = gap_q;
    act_d       = act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    valid_d     = 1'b0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    dout_d      = '0;
    ovf_d       = in_valid && pend_full_q;
    load        = 1'b0;
    load_src    = pend_q;
    sym_nxt     = sym_q + 1'b1;

    if (capture) begin
      pend_d      = in_frame;
      pend_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_full_q) load = 1'b1;
      end
      S_STREAM: begin
        if (sym_q != LAST) begin
          sym_d   = sym_nxt;
          valid_d = 1'b1;
          last_d  = (sym_nxt == LAST);
          dout_d  = pick(act_q, sym_nxt);
        end else if (GAP > 0) begin
          state_d = S_GAP;
          gap_d   = 8'(GAP);
        end else if (pend_full_q) begin
          load = 1'b1;
        end else if (capture) begin
          // Frame arriving on the last-symbol edge bypasses the pending slot.
          load     = 1'b1;
          load_src = in_frame;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q <= 8'd1) begin
          if (pend_full_q) load = 1'b1;
          else             state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      act_d       = load_src;
      pend_full_d = 1'b0;
      state_d     = S_STREAM;
      sym_d       = '0;
      valid_d     = 1'b1;
      first_d     = 1'b1;
      dout_d      = pick(load_src, '0);
    end
  end

  // State and output registers; reset discards both slots at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sym_q       <= '0;
      gap_q       <= '0;
      act_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      sym_q       <= sym_d;
      gap_q       <= gap_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      valid_q     <= valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      ovf_q       <= ovf_d;
      dout_q      <= dout_d;
    end
  end

endmodule

// File: tb/tb_llr_block_to_stream.sv
// tb/tb_llr_block_to_stream.sv - randomized scoreboard bench for llr_block_to_stream (GAP=0 and GAP=12)
module tb_llr_block_to_stream;

  localparam int B    = 32;
  localparam int BPS  = 2;
  localparam int S    = 29;
  localparam int AW   = BPS * S * B;
  localparam int OW   = BPS * B;
  localparam int NF   = 16;
  localparam int MAXC = 2000;

  logic clk = 1'b0;
  logic reset_n;
  logic in_valid;
  logic [AW-1:0] e1i, e2i, exi;
  logic [1:0] ir, ov, ff, fl, of;
  logic [1:0][OW-1:0] e1o, e2o, exo;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  // Reference model: per-instance schedule of which frame/symbol each edge must show.
  int   exp_f   [2][MAXC];
  int   exp_s   [2][MAXC];
  bit   exp_ovf [2][MAXC];
  int   last_end   [2];
  int   pend_acc   [2];
  int   pend_start [2];
  logic [31:0] llr [NF][3][BPS][S];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  llr_block_to_stream #(.BITS(B), .BITS_PER_SYMBOL(BPS), .SYMBOLS(S), .GAP(0)) u0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[0]),
    .encoder1_data_in(e1i), .encoder2_data_in(e2i), .extrinsic_in(exi),
    .out_valid(ov[0]), .encoder1_data_out(e1o[0]), .encoder2_data_out(e2o[0]),
    .extrinsic_out(exo[0]), .frame_first(ff[0]), .frame_last(fl[0]), .overflow(of[0]));

  llr_block_to_stream #(.BITS(B), .BITS_PER_SYMBOL(BPS), .SYMBOLS(S), .GAP(12)) u12 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[1]),
    .encoder1_data_in(e1i), .encoder2_data_in(e2i), .extrinsic_in(exi),
    .out_valid(ov[1]), .encoder1_data_out(e1o[1]), .encoder2_data_out(e2o[1]),
    .extrinsic_out(exo[1]), .frame_first(ff[1]), .frame_last(fl[1]), .overflow(of[1]));

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : 12;
  endfunction

  function automatic bit busy(input int k, input int n);
    return (pend_acc[k] <= n) && (n < pend_start[k]);
  endfunction

  task automatic chk(input string tag, input int k, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s u%0d cyc=%0d got=%h want=%h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic model_reset(input int n);
    for (int k = 0; k < 2; k++) begin
      for (int t = n; t < MAXC; t++) begin
        exp_f[k][t] = -1; exp_s[k][t] = -1; exp_ovf[k][t] = 1'b0;
      end
      last_end[k] = -1000; pend_acc[k] = 0; pend_start[k] = -1;
    end
  endtask

  // Frame accepted at edge a: starts one edge later, not before the previous frame
  // plus GAP idle cycles; with GAP=0 a capture on the edge right after the last symbol
  // is shown on that very edge.
  task automatic schedule(input int k, input int f, input int a);
    int st;
    if (gap_of(k) == 0 && a == last_end[k] + 1) st = a;
    else st = (a + 1 > last_end[k] + 1 + gap_of(k)) ? a + 1 : last_end[k] + 1 + gap_of(k);
    for (int s = 0; s < S; s++) begin
      if (st + s < MAXC) begin exp_f[k][st+s] = f; exp_s[k][st+s] = s; end
    end
    pend_acc[k] = a; pend_start[k] = st; last_end[k] = st + S - 1;
  endtask

  task automatic scramble();
    for (int w = 0; w < AW / 32; w++) begin
      e1i[w*32 +: 32] = $urandom; e2i[w*32 +: 32] = $urandom; exi[w*32 +: 32] = $urandom;
    end
  endtask

  task automatic offer(input int f);
    int n;
    n = cyc;
    for (int k = 0; k < 2; k++) begin
      if (!busy(k, n)) schedule(k, f, n + 1);
      else if (n + 1 < MAXC) exp_ovf[k][n+1] = 1'b1;
    end
    for (int j = 0; j < BPS; j++) begin
      for (int i = 0; i < S; i++) begin
        e1i[(j*S+i)*B +: B] = llr[f][0][j][i];
        e2i[(j*S+i)*B +: B] = llr[f][1][j][i];
        exi[(j*S+i)*B +: B] = llr[f][2][j][i];
      end
    end
    in_valid = 1'b1;
  endtask

  task automatic check_cycle();
    int n, f, s;
    logic [191:0] ed;
    n = cyc;
    if (n >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", n, MAXC);
      $fatal(1);
    end
    for (int k = 0; k < 2; k++) begin
      f = exp_f[k][n]; s = exp_s[k][n];
      ed = '0;
      if (f >= 0) begin
        for (int a = 0; a < 3; a++)
          for (int j = 0; j < BPS; j++)
            ed[a*OW + j*B +: B] = llr[f][a][j][s];
      end
      chk("out_valid",   k, 192'(ov[k]), 192'(f >= 0));
      chk("frame_first", k, 192'(ff[k]), 192'(f >= 0 && s == 0));
      chk("frame_last",  k, 192'(fl[k]), 192'(f >= 0 && s == S - 1));
      chk("overflow",    k, 192'(of[k]), 192'(exp_ovf[k][n]));
      chk("in_ready",    k, 192'(ir[k]), 192'(!busy(k, n)));
      chk("data",        k, {exo[k], e2o[k], e1o[k]}, ed);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic run(input int n);
    repeat (n) next_cycle();
  endtask

  initial begin
    int guard;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    scramble();
    model_reset(0);
    for (int f = 0; f < NF; f++)
      for (int a = 0; a < 3; a++)
        for (int j = 0; j < BPS; j++)
          for (int i = 0; i < S; i++)
            llr[f][a][j][i] = (f == 0) ? {8'(a + 1), 8'(j), 16'(i)} : $urandom;

    // Reset state, then a single tagged frame
    run(2);
    reset_n = 1'b1;
    next_cycle();
    offer(0); next_cycle();
    run(34);

    // Back-to-back frames offered while the first streams
    offer(1); next_cycle();
    run(2);
    offer(2); next_cycle();
    run(75);

    // Overflow: third frame offered while pending is full
    offer(3); next_cycle();
    run(2);
    offer(4); next_cycle();
    offer(5); next_cycle();
    run(80);

    // Frame captured on the edge right after the last symbol
    offer(6); next_cycle();
    guard = 0;
    while (cyc < last_end[0] && guard < 100) begin next_cycle(); guard++; end
    tests++;
    assert (guard < 100) else begin fails++; $error("FAIL wait_last got=%0d want<100", guard); end
    offer(7); next_cycle();
    run(80);

    // Random traffic including offers against a full pending slot
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) offer(8 + $urandom_range(0, NF - 9));
      next_cycle();
    end
    run(120);

    // Reset at symbol 10 of a frame with another frame pending
    offer(8); next_cycle();
    run(3);
    offer(9); next_cycle();
    guard = 0;
    while (exp_s[0][cyc] != 10 && guard < 100) begin next_cycle(); guard++; end
    tests++;
    assert (guard < 100) else begin fails++; $error("FAIL wait_sym10 got=%0d want<100", guard); end
    reset_n = 1'b0;
    model_reset(cyc);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", k, 192'(ov[k]), 192'(0));
      chk("rst_data",      k, {exo[k], e2o[k], e1o[k]}, 192'(0));
      chk("rst_in_ready",  k, 192'(ir[k]), 192'(1));
    end
    run(3);
    reset_n = 1'b1;
    run(40);
    offer(10); next_cycle();
    run(75);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
